twiddle_seq: RTL and testbench
==============================

Name: twiddle_seq

Overview:
Parametrised twiddle-factor sequencer for the parallel radix-2 DIF FFT datapath. It supersedes the single-lane free-running coefficient cycler with four additions: per-stage stride addressing across all log2(N) stages, LANES coefficients per clock for the parallel butterfly bank, a start/enable/valid handshake, and a latched inverse-FFT (conjugate) mode. It sits between the coefficient ROM data module, which drives a flat table bus, and the butterfly stage array.

Parameters:
NBITS, 16, width of each real/imag part (two's complement)
N, 128, FFT size; power of 2, N >= 4
LOG2N, 7, log2(N); must be consistent with N
LANES, 4, butterflies served per clock; power of 2, 1 <= LANES <= N/2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
coeff_table  in  N/2*2*NBITS  twiddles W^0..W^(N/2-1); entry k = {re,im} at bits [(N/2-k)*2*NBITS-1 -: 2*NBITS] (entry 0 at MSB)
start  in  1  request one full transform sweep; sampled only in IDLE
inverse  in  1  conjugate mode; latched when start is accepted
en  in  1  advance enable (downstream ready); stalls the sequence when low
coeff_out  out  LANES*2*NBITS  lane l at bits [(LANES-l)*2*NBITS-1 -: 2*NBITS]; lane 0 at MSB
valid  out  1  coeff_out holds a new coefficient group this cycle
stage_out  out  LOG2N  stage index of the current coeff_out
last  out  1  with valid: final group of the final stage
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last group

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; coeff_out=0, valid=0, stage_out=0, last=0, busy=0, done=0; all counters and the inverse latch cleared. Reset mid-sweep aborts the sweep; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: go to RUN, latch inverse, cyc=0, stg=0. start is a level sampled only in IDLE; start in RUN or DONE is ignored.
- RUN: each cycle with en=1, register one group, then advance cyc. When cyc = N/(2*LANES)-1, wrap cyc to 0 and increment stg. On the group with stg=LOG2N-1 and the final cyc, assert last and go to DONE.
- RUN, en=0: counters hold, valid=0 on the next cycle, coeff_out/stage_out hold their last values.
- Group contents: butterfly b = cyc*LANES + l. Twiddle index k = (b mod (N>>(stg+1))) << stg, which is always < N/2. Compute with LOG2N-bit unsigned arithmetic: mask and shift only, no divider.
- inverse=1: output {re, -im}. Negation is two's complement; -(-2^(NBITS-1)) saturates to 2^(NBITS-1)-1.
- Latency: one register stage. Group g appears on coeff_out the cycle after the en=1 cycle that generated it. The first valid is 1 cycle after start is accepted when en=1. valid mirrors the registered en&&RUN condition.
- DONE: done=1 and busy=0 for exactly one cycle, valid=0, then IDLE. A start seen in DONE is ignored; it must be held until IDLE.
- Stage count: each sweep is LOG2N*N/(2*LANES) valid groups.
- coeff_table is sampled combinationally at generation time. Changing the table mid-sweep takes effect on the next generated group.

Test Plan:
- N=8, LANES=1, NBITS=4, table re=k, im=k+4, en=1, start pulse -> 12 valid groups, re sequence 0,1,2,3 | 0,2,0,2 | 0,0,0,0; stage_out 0,0,0,0,1,1,1,1,2,2,2,2; last on the 12th group; done one cycle later.
- Same setup with LANES=2 -> 6 groups {0,1},{2,3},{0,2},{0,2},{0,0},{0,0}, lane 0 at MSB; last on the 6th group.
- inverse=1, table entry 1 im=-8 (4-bit) -> im out=+7 (saturated); entry 2 im=+3 -> -3; re unchanged. Toggling inverse mid-sweep has no effect.
- N=8, LANES=1, en low for 3 cycles after the 2nd group -> valid low for 3 cycles, coeff_out holds re=1, sequence resumes with re=2; still 12 groups total.
- Assert rst low at the 5th group -> all outputs 0 immediately (asynchronous), no done pulse. A new start after release restarts at stage 0, group 0.
- start held high through a full sweep plus 2 cycles -> a second sweep begins only after IDLE is reached, i.e. the first valid of sweep 2 appears 2 cycles after done.

Source files
------------

// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer for a parallel radix-2 DIF FFT: walks all stages with per-stage
// stride addressing and presents LANES coefficients per clock from a flat ROM table bus.
module twiddle_seq #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned N     = 128,
  parameter int unsigned LOG2N = 7,
  parameter int unsigned LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(N/2)*2*NBITS-1:0]   coeff_table,
  input  logic                       start,
  input  logic                       inverse,
  input  logic                       en,
  output logic [LANES*2*NBITS-1:0]   coeff_out,
  output logic                       valid,
  output logic [LOG2N-1:0]           stage_out,
  output logic                       last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned HalfN  = N / 2;
  localparam int unsigned Groups = N / (2 * LANES);
  localparam int unsigned CycW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam int unsigned KW     = LOG2N - 1;

  localparam logic [CycW-1:0]  CycLast = CycW'(Groups - 1);
  localparam logic [LOG2N-1:0] StgLast = LOG2N'(LOG2N - 1);

  localparam logic signed [NBITS-1:0] MinVal = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic signed [NBITS-1:0] MaxVal = ~MinVal;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CycW-1:0]  cyc_q;
  logic [LOG2N-1:0] stg_q;
  logic             inv_q;

  logic [2*NBITS-1:0]       tbl [HalfN];
  logic [LANES*2*NBITS-1:0] grp;
  logic [LOG2N-1:0]         mask;

  for (genvar k = 0; k < HalfN; k++) begin : g_tbl
    assign tbl[k] = coeff_table[(HalfN-k)*2*NBITS-1 -: 2*NBITS];
  end

  // Butterflies within a stage repeat every N>>(stg+1); mask picks the position in that span.
  assign mask = LOG2N'((N >> (32'(stg_q) + 1)) - 1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LOG2N-1:0]         b;
    logic [KW-1:0]            k;
    logic signed [NBITS-1:0]  re;
    logic signed [NBITS-1:0]  im;
    logic signed [NBITS-1:0]  im_n;

    assign b = LOG2N'(cyc_q) * LOG2N'(LANES) + LOG2N'(l);
    // Index is always below N/2, so the top bit of the shifted value is dropped.
    assign k = KW'((b & mask) << stg_q);
    assign {re, im} = tbl[k];
    assign im_n = (im == MinVal) ? MaxVal : -im;
    assign grp[(LANES-l)*2*NBITS-1 -: 2*NBITS] = {re, inv_q ? im_n : im};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      stg_q     <= '0;
      inv_q     <= 1'b0;
      coeff_out <= '0;
      valid     <= 1'b0;
      stage_out <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid <= 1'b0;
      last  <= 1'b0;
      done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            inv_q   <= inverse;
            cyc_q   <= '0;
            stg_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          if (en) begin
            coeff_out <= grp;
            stage_out <= stg_q;
            valid     <= 1'b1;
            if (cyc_q == CycLast) begin
              cyc_q <= '0;
              if (stg_q == StgLast) begin
                last    <= 1'b1;
                busy    <= 1'b0;
                state_q <= StDone;
              end else begin
                stg_q <= stg_q + 1'b1;
              end
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: two N=8, NBITS=4 instances (LANES=1 and LANES=2) sharing stimulus,
// each checked against an arithmetic model of the stage/stride twiddle schedule.
module tb_twiddle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] coeff_table;
  logic        start, inverse, en;

  logic [7:0]  cf1;
  logic [15:0] cf2;
  logic        v1, v2, l1, l2, b1, b2, d1, d2;
  logic [2:0]  s1, s2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] tre [4];
  logic [3:0] tim [4];
  bit         exp_inv;
  int         gidx [2];
  bit         prev_last [2];
  int         sweeps [2];

  always #5 clk = ~clk;

  twiddle_seq #(.NBITS(4), .N(8), .LOG2N(3), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .coeff_table(coeff_table), .start(start), .inverse(inverse),
    .en(en), .coeff_out(cf1), .valid(v1), .stage_out(s1), .last(l1), .busy(b1), .done(d1)
  );

  twiddle_seq #(.NBITS(4), .N(8), .LOG2N(3), .LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .coeff_table(coeff_table), .start(start), .inverse(inverse),
    .en(en), .coeff_out(cf2), .valid(v2), .stage_out(s2), .last(l2), .busy(b2), .done(d2)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("d%0d_%s", d, s);
  endfunction

  // Stage s: butterfly b pairs with twiddle W_N^((b mod (N/2^(s+1))) * 2^s).
  function automatic logic [63:0] exp_group(input int lanes, input int g);
    int groups, s, c, b, k, im;
    logic [63:0] r;
    groups = 8 / (2 * lanes);
    s = g / groups;
    c = g % groups;
    r = '0;
    for (int l = 0; l < lanes; l++) begin
      b  = c * lanes + l;
      k  = (b % (8 / (2 ** (s + 1)))) * (2 ** s);
      im = $signed(tim[k]);
      if (exp_inv) im = (im == -8) ? 7 : -im;
      r = (r << 8) | {56'b0, tre[k], im[3:0]};
    end
    return r;
  endfunction

  task automatic mon(input int d, input int lanes, input logic v, input logic lst,
                     input logic dn, input logic bsy, input logic [2:0] stg,
                     input logic [63:0] cf);
    int total, groups;
    total  = 12 / lanes;
    groups = 4 / lanes;
    check_eq(tg(d, "done"), 64'(dn), 64'(prev_last[d]));
    if (dn) begin
      check_eq(tg(d, "group_count"), 64'(gidx[d]), 64'(total));
      check_eq(tg(d, "busy_done"), 64'(bsy), 64'd0);
      gidx[d] = 0;
      sweeps[d]++;
    end
    if (v) begin
      if (gidx[d] >= total) begin
        check_eq(tg(d, "overrun"), 64'(gidx[d]), 64'(total - 1));
      end else begin
        check_eq(tg(d, "coeff"), cf, exp_group(lanes, gidx[d]));
        check_eq(tg(d, "stage"), 64'(stg), 64'(gidx[d] / groups));
        check_eq(tg(d, "last"), 64'(lst), 64'(gidx[d] == total - 1));
        if (gidx[d] != total - 1) check_eq(tg(d, "busy_run"), 64'(bsy), 64'd1);
      end
      gidx[d]++;
    end else begin
      check_eq(tg(d, "last_idle"), 64'(lst), 64'd0);
    end
    prev_last[d] = v && lst;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      gidx      = '{0, 0};
      prev_last = '{0, 0};
    end else begin
      mon(0, 1, v1, l1, d1, b1, s1, 64'(cf1));
      mon(1, 2, v2, l2, d2, b2, s2, 64'(cf2));
    end
  end

  task automatic pack_table();
    for (int k = 0; k < 4; k++) coeff_table[(4-k)*8-1 -: 8] = {tre[k], tim[k]};
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_d1"}, {51'b0, cf1, v1, s1, l1, b1, d1}, 64'd0);
    check_eq({tag, "_d2"}, {43'b0, cf2, v2, s2, l2, b2, d2}, 64'd0);
  endtask

  // Runs until both instances have been idle for three cycles; optionally jitters en/inverse.
  task automatic wait_idle(input bit rnd);
    int idle_cnt, cyc;
    idle_cnt = 0;
    cyc = 0;
    while (idle_cnt < 3 && cyc < 400) begin
      @(negedge clk); #1;
      if (rnd) begin
        en      = ($urandom_range(3) != 0);
        inverse = 1'($urandom_range(1));
      end
      if (!b1 && !b2) idle_cnt++;
      else idle_cnt = 0;
      cyc++;
    end
    en = 1'b1;
    if (idle_cnt < 3) check_eq("idle_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic pulse_start(input bit inv);
    @(negedge clk); #1;
    exp_inv = inv;
    inverse = inv;
    en      = 1'b1;
    start   = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input bit inv, input bit rnd);
    int c0, c1;
    c0 = sweeps[0];
    c1 = sweeps[1];
    pulse_start(inv);
    wait_idle(rnd);
    check_eq("sweeps_d1", 64'(sweeps[0] - c0), 64'd1);
    check_eq("sweeps_d2", 64'(sweeps[1] - c1), 64'd1);
  endtask

  task automatic wait_group(input int g);
    int tmo;
    tmo = 0;
    while (gidx[0] < g && tmo < 100) begin
      @(negedge clk); #1;
      tmo++;
    end
    if (gidx[0] < g) check_eq("group_timeout", 64'(gidx[0]), 64'(g));
  endtask

  initial begin
    int c0, tmo;
    rst = 1'b0; start = 1'b0; inverse = 1'b0; en = 1'b1; exp_inv = 1'b0;
    sweeps = '{0, 0};
    for (int k = 0; k < 4; k++) begin
      tre[k] = 4'(k);
      tim[k] = 4'(k + 4);
    end
    pack_table();
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table re=k, im=k+4, en always high.
    run_sweep(1'b0, 1'b0);

    // Stall: en low for three cycles after the second group.
    pulse_start(1'b0);
    wait_group(2);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("stall_valid", 64'(v1), 64'd0);
      check_eq("stall_hold", 64'(cf1), exp_group(1, 1));
    end
    en = 1'b1;
    wait_idle(1'b0);

    // Inverse with saturating negation; inverse toggled mid-sweep must not matter.
    tre[1] = 4'h5; tim[1] = 4'h8;
    tre[2] = 4'h6; tim[2] = 4'h3;
    tre[0] = 4'($urandom); tim[0] = 4'($urandom);
    tre[3] = 4'($urandom); tim[3] = 4'($urandom);
    pack_table();
    run_sweep(1'b1, 1'b1);

    // Asynchronous reset at the 5th group aborts the sweep with no done pulse.
    c0 = sweeps[0];
    pulse_start(1'b0);
    wait_group(5);
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) @(negedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("no_done_after_abort", 64'(sweeps[0]), 64'(c0));
    run_sweep(1'b0, 1'b0);

    // start held high: sweep 2 waits for IDLE, first valid two cycles after done.
    @(negedge clk); #1;
    exp_inv = 1'($urandom_range(1));
    inverse = exp_inv;
    start   = 1'b1;
    tmo = 0;
    while (!d1 && tmo < 100) begin
      @(negedge clk); #1;
      tmo++;
    end
    check_eq("held_done_seen", 64'(d1), 64'd1);
    @(negedge clk); #1;
    check_eq("held_gap", 64'(v1), 64'd0);
    @(negedge clk); #1;
    check_eq("held_restart", 64'(v1), 64'd1);
    start = 1'b0;
    wait_idle(1'b0);

    // Random tables, random inverse, random en stalls.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        tre[k] = 4'($urandom);
        tim[k] = 4'($urandom);
      end
      pack_table();
      run_sweep(1'($urandom_range(1)), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
